csa_seq_adder: RTL



---
 rtl/csa_pkg.sv | 23 ++
 rtl/csa.sv | 31 +++
 rtl/csa_seq_adder.sv | 115 +++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared types and constants for the sliced carry-select adder.
// Imported by the slice adder wrapper and its controller.
package csa_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for a slice counter; never narrower than 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/csa.sv
// 4-bit carry select adder: 2-bit ripple low half, upper half
// precomputed for both carries and picked by the low carry.
module csa (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    // Low half ripples from cin.
    assign lo  = {1'b0, a[1:0]}
               + {1'b0, b[1:0]}
               + {2'b00, cin};

    // Upper half assuming carry 0 and carry 1.
    assign hi0 = {1'b0, a[3:2]}
               + {1'b0, b[3:2]};
    assign hi1 = {1'b0, a[3:2]}
               + {1'b0, b[3:2]}
               + 3'd1;

    // Select the upper half by the real low carry.
    assign s    = {lo[2] ? hi1[1:0] : hi0[1:0], lo[1:0]};
    assign cout = lo[2] ? hi1[2] : hi0[2];

endmodule

// File: rtl/csa_seq_adder.sv
// Wide add/subtract sequenced through one 4-bit csa,
// one slice per clock, LSB slice first, valid/ready on both sides.
module csa_seq_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW     = clog2(NSLICE);
    localparam int BW     = KW + 2;

    localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);
    localparam logic [KW-1:0] KONE  = KW'(1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c;
    logic [KW-1:0]    k;
    logic [BW-1:0]    base;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_c;

    logic a_msb;
    logic b_msb;

    // Bit offset of the current slice.
    assign base = {k, 2'b00};

    assign sl_a  = a_q[base +: SLICE_W];
    assign sl_b  = b_q[base +: SLICE_W];
    assign a_msb = a_q[WIDTH-1];
    assign b_msb = b_q[WIDTH-1];

    csa u_csa (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (c),
        .s    (sl_s),
        .cout (sl_c)
    );

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c         <= 1'b0;
            k         <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= op_sub ? ~b : b;
                        c        <= op_sub | cin;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: SLICE_W] <= sl_s;
                    c <= sl_c;
                    k <= k + KONE;
                    if (k == KLAST) begin
                        cout      <= sl_c;
                        ovf       <= (a_msb == b_msb)
                                  && (sl_s[SLICE_W-1] != a_msb);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
